// File: rtl/stm_gain_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// stm_gain_sequencer_pkg
// Shared STM definitions for the gain-frame read path: memory read latency,
// address/index widths, sequencer state encoding and the tag that travels
// alongside each issued memory address.
// -----------------------------------------------------------------------------
package stm_gain_sequencer_pkg;

    // Cycles from GAIN_ADDR presented to matching VALUE word on the bus.
    localparam int GAIN_MEM_LATENCY = 2;

    localparam int GAIN_IDX_W  = 10;
    localparam int GAIN_ADDR_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } gain_seq_state_t;

    // Travels with each issued address so the returning word can be tagged.
    typedef struct packed {
        logic                   vld;
        logic                   last;
        logic [GAIN_ADDR_W-1:0] addr;
    } gain_tag_t;

endpackage

// File: rtl/stm_gain_unpack.sv
// -----------------------------------------------------------------------------
// stm_gain_unpack
// Picks the 16-bit phase/intensity pair of one transducer out of a 64-bit
// memory word (lane = addr[1:0]) and registers it as an output beat.
//
// Ports:
//   CLK, RST_N      clock, async active-low reset
//   VALUE           memory read word, aligned with TAG
//   TAG             valid/last/addr of the address that produced VALUE
//   DOUT_VALID      beat valid
//   DOUT_ADDR       transducer index of the beat
//   PHASE           low byte of the selected lane
//   INTENSITY       high byte of the selected lane
//   DONE            beat is the last one of its frame
// -----------------------------------------------------------------------------
module stm_gain_unpack
    import stm_gain_sequencer_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [63:0]            VALUE,
    input  gain_tag_t              TAG,
    output logic                   DOUT_VALID,
    output logic [GAIN_ADDR_W-1:0] DOUT_ADDR,
    output logic [7:0]             PHASE,
    output logic [7:0]             INTENSITY,
    output logic                   DONE
);

    logic [15:0] pair;

    always_comb begin
        pair = VALUE[15:0];
        case (TAG.addr[1:0])
            2'd0: pair = VALUE[15:0];
            2'd1: pair = VALUE[31:16];
            2'd2: pair = VALUE[47:32];
            2'd3: pair = VALUE[63:48];
            default: pair = VALUE[15:0];
        endcase
    end

    // Data registers only move on a valid tag so the outputs hold the last
    // beat between frames.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DOUT_VALID <= 1'b0;
            DONE       <= 1'b0;
            DOUT_ADDR  <= '0;
            PHASE      <= '0;
            INTENSITY  <= '0;
        end else begin
            DOUT_VALID <= TAG.vld;
            DONE       <= TAG.vld & TAG.last;
            if (TAG.vld) begin
                DOUT_ADDR <= TAG.addr;
                PHASE     <= pair[7:0];
                INTENSITY <= pair[15:8];
            end
        end
    end

endmodule

// File: rtl/stm_gain_sequencer.sv
// -----------------------------------------------------------------------------
// stm_gain_sequencer
// Reads one gain frame (DEPTH transducers) from the gain-STM segment memory
// per START and streams it out as phase/intensity beats. A START that arrives
// while a frame is running is parked in a one-entry slot (latest wins) and is
// launched with no gap once the current frame issues its last address.
//
// Ports:
//   CLK, RST_N               clock, async active-low reset
//   START                    one-cycle frame request
//   REQ_IDX, REQ_SEGMENT     frame index / segment, sampled with START
//   BUSY                     frame running or beats still in flight
//   GAIN_IDX, GAIN_ADDR,     memory address outputs
//   SEGMENT
//   VALUE                    memory read data (GAIN_MEM_LATENCY cycles late)
//   DOUT_VALID, DOUT_ADDR,   output beat stream
//   PHASE, INTENSITY
//   DONE                     pulse on the last beat of each frame
// -----------------------------------------------------------------------------
module stm_gain_sequencer
    import stm_gain_sequencer_pkg::*;
#(
    parameter int DEPTH = 249
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   START,
    input  logic [GAIN_IDX_W-1:0]  REQ_IDX,
    input  logic                   REQ_SEGMENT,
    output logic                   BUSY,
    output logic [GAIN_IDX_W-1:0]  GAIN_IDX,
    output logic [GAIN_ADDR_W-1:0] GAIN_ADDR,
    output logic                   SEGMENT,
    input  logic [63:0]            VALUE,
    output logic                   DOUT_VALID,
    output logic [GAIN_ADDR_W-1:0] DOUT_ADDR,
    output logic [7:0]             PHASE,
    output logic [7:0]             INTENSITY,
    output logic                   DONE
);

    localparam logic [GAIN_ADDR_W-1:0] LAST_ADDR = GAIN_ADDR_W'(DEPTH - 1);

    gain_seq_state_t       state;
    logic                  pend_vld;
    logic [GAIN_IDX_W-1:0] pend_idx;
    logic                  pend_seg;

    // ---------------- sequencer FSM, address counter, pending slot ----------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            GAIN_IDX  <= '0;
            GAIN_ADDR <= '0;
            SEGMENT   <= 1'b0;
            pend_vld  <= 1'b0;
            pend_idx  <= '0;
            pend_seg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        GAIN_IDX  <= REQ_IDX;
                        SEGMENT   <= REQ_SEGMENT;
                        GAIN_ADDR <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (GAIN_ADDR == LAST_ADDR) begin
                        // A START on the last-issue cycle is newer than the
                        // parked request, so it takes precedence.
                        if (START) begin
                            GAIN_IDX  <= REQ_IDX;
                            SEGMENT   <= REQ_SEGMENT;
                            GAIN_ADDR <= '0;
                            pend_vld  <= 1'b0;
                        end else if (pend_vld) begin
                            GAIN_IDX  <= pend_idx;
                            SEGMENT   <= pend_seg;
                            GAIN_ADDR <= '0;
                            pend_vld  <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        GAIN_ADDR <= GAIN_ADDR + 1'b1;
                        if (START) begin
                            pend_vld <= 1'b1;
                            pend_idx <= REQ_IDX;
                            pend_seg <= REQ_SEGMENT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------- tag pipeline matching the memory latency --------------
    gain_tag_t issue_tag;
    gain_tag_t tag_pipe [1:GAIN_MEM_LATENCY];

    always_comb begin
        issue_tag.vld  = (state == RUN);
        issue_tag.last = (GAIN_ADDR == LAST_ADDR);
        issue_tag.addr = GAIN_ADDR;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 1; i <= GAIN_MEM_LATENCY; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[1] <= issue_tag;
            for (int i = 2; i <= GAIN_MEM_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    // ---------------- unpack -------------------------------------------------
    stm_gain_unpack u_unpack (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .VALUE      (VALUE),
        .TAG        (tag_pipe[GAIN_MEM_LATENCY]),
        .DOUT_VALID (DOUT_VALID),
        .DOUT_ADDR  (DOUT_ADDR),
        .PHASE      (PHASE),
        .INTENSITY  (INTENSITY),
        .DONE       (DONE)
    );

    // Busy covers issue plus every beat still travelling to the output.
    always_comb begin
        BUSY = (state == RUN) | DOUT_VALID;
        for (int i = 1; i <= GAIN_MEM_LATENCY; i++) BUSY = BUSY | tag_pipe[i].vld;
    end

endmodule

// File: tb/tb_stm_gain_sequencer.sv
module tb_stm_gain_sequencer;

  localparam int DEPTH = 249;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic [9:0]  REQ_IDX = '0;
  logic        REQ_SEGMENT = 1'b0;
  logic        BUSY, SEGMENT, DOUT_VALID, DONE;
  logic [9:0]  GAIN_IDX;
  logic [7:0]  GAIN_ADDR, DOUT_ADDR, PHASE, INTENSITY;
  logic [63:0] VALUE = '0, m0 = '0;

  // second build with DEPTH=1
  logic        s1_start = 1'b0;
  logic [9:0]  s1_idx = '0;
  logic        s1_seg = 1'b0;
  logic        s1_busy, s1_segment, s1_valid, s1_done;
  logic [9:0]  s1_gidx;
  logic [7:0]  s1_gaddr, s1_daddr, s1_phase, s1_int;
  logic [63:0] s1_value = '0, s1_m0 = '0;

  always #5 CLK = ~CLK;

  stm_gain_sequencer #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .REQ_IDX(REQ_IDX), .REQ_SEGMENT(REQ_SEGMENT),
    .BUSY(BUSY), .GAIN_IDX(GAIN_IDX), .GAIN_ADDR(GAIN_ADDR), .SEGMENT(SEGMENT), .VALUE(VALUE),
    .DOUT_VALID(DOUT_VALID), .DOUT_ADDR(DOUT_ADDR), .PHASE(PHASE), .INTENSITY(INTENSITY), .DONE(DONE)
  );

  stm_gain_sequencer #(.DEPTH(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .START(s1_start), .REQ_IDX(s1_idx), .REQ_SEGMENT(s1_seg),
    .BUSY(s1_busy), .GAIN_IDX(s1_gidx), .GAIN_ADDR(s1_gaddr), .SEGMENT(s1_segment), .VALUE(s1_value),
    .DOUT_VALID(s1_valid), .DOUT_ADDR(s1_daddr), .PHASE(s1_phase), .INTENSITY(s1_int), .DONE(s1_done)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [63:0] seed = 64'h0;

  // "Preloaded" random memory: a seeded hash of (segment, index, address).
  function automatic logic [63:0] word(input logic seg, input logic [9:0] idx, input logic [7:0] addr);
    logic [63:0] x;
    x = seed ^ (64'(seg) << 40) ^ (64'(idx) << 20) ^ 64'(addr);
    x = x * 64'h9E3779B97F4A7C15;
    x = x ^ (x >> 29);
    x = x * 64'hBF58476D1CE4E5B9;
    x = x ^ (x >> 32);
    return x;
  endfunction

  // Memory: VALUE is the word for the address presented two cycles earlier.
  always @(posedge CLK) begin
    m0       <= word(SEGMENT, GAIN_IDX, GAIN_ADDR);
    VALUE    <= m0;
    s1_m0    <= word(s1_segment, s1_gidx, s1_gaddr);
    s1_value <= s1_m0;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic [7:0] ph;
    logic [7:0] in;
    logic       done;
  } beat_t;

  beat_t      q[$];
  logic [9:0] started[$];
  int         done_cycs[$];
  int         left = 0;
  int         busy_end = -1;
  logic       pend_v = 1'b0;
  logic [9:0] pend_i = '0;
  logic       pend_s = 1'b0;

  // A frame accepted at edge e issues address k after that edge and its beat
  // appears k+3 edges later; the last beat is DEPTH+2 edges after e.
  function automatic void begin_frame(input logic [9:0] idx, input logic seg);
    logic [63:0] w;
    beat_t b;
    for (int k = 0; k < DEPTH; k++) begin
      w = word(seg, idx, 8'(k));
      b.cyc  = cyc + 3 + k;
      b.addr = 8'(k);
      b.ph   = 8'(w >> (16 * (k % 4)));
      b.in   = 8'(w >> (16 * (k % 4) + 8));
      b.done = (k == DEPTH - 1);
      q.push_back(b);
    end
    left = DEPTH;
    busy_end = cyc + 2 + DEPTH;
    started.push_back(idx);
  endfunction

  always @(posedge CLK) begin
    cyc++;
    if (!RST_N) begin
      left = 0;
      pend_v = 1'b0;
      busy_end = -1;
      q.delete();
    end else begin
      if (left > 0) left--;
      if (left == 0) begin
        if (START) begin
          begin_frame(REQ_IDX, REQ_SEGMENT);
          pend_v = 1'b0;
        end else if (pend_v) begin
          begin_frame(pend_i, pend_s);
          pend_v = 1'b0;
        end
      end else if (START) begin
        pend_v = 1'b1;
        pend_i = REQ_IDX;
        pend_s = REQ_SEGMENT;
      end
    end
  end

  // ---------------- monitor ----------------
  beat_t mb;
  always @(negedge CLK) begin
    if (RST_N) begin
      while (q.size() != 0 && q[0].cyc < cyc) begin
        chk("missing_beat_addr", -1, q[0].addr);
        void'(q.pop_front());
      end
      chk("busy", BUSY, (left > 0) || (cyc <= busy_end));
      if (DOUT_VALID) begin
        if (DONE) done_cycs.push_back(cyc);
        if (q.size() == 0) begin
          chk("unexpected_beat_addr", DOUT_ADDR, -1);
        end else begin
          mb = q.pop_front();
          chk("beat_cycle", cyc, mb.cyc);
          chk("dout_addr", DOUT_ADDR, mb.addr);
          chk("phase", PHASE, mb.ph);
          chk("intensity", INTENSITY, mb.in);
          chk("done", DONE, mb.done);
        end
      end else begin
        chk("done_without_valid", DONE, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic s, input logic [9:0] i, input logic g);
    @(negedge CLK);
    #1;
    START = s;
    REQ_IDX = i;
    REQ_SEGMENT = g;
    @(posedge CLK);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 10'($urandom), 1'($urandom));
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge CLK);
    #1 START = 1'b0;
    while ((BUSY || q.size() != 0) && n < 3000) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk("idle_timeout", n < 3000, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_valid"}, DOUT_VALID, 0);
    chk({tag, "_done"}, DONE, 0);
    chk({tag, "_gidx"}, GAIN_IDX, 0);
    chk({tag, "_gaddr"}, GAIN_ADDR, 0);
    chk({tag, "_seg"}, SEGMENT, 0);
    chk({tag, "_daddr"}, DOUT_ADDR, 0);
    chk({tag, "_phase"}, PHASE, 0);
    chk({tag, "_int"}, INTENSITY, 0);
  endtask

  initial begin
    logic [63:0] w1;
    int s0;
    seed = {$urandom, $urandom};

    // reset state
    repeat (3) @(negedge CLK);
    #1 chk_reset_outputs("rst");
    chk("rst1_busy", s1_busy, 0);
    chk("rst1_valid", s1_valid, 0);
    RST_N = 1'b1;

    // single frame idx 5 seg 0
    tick(1'b1, 10'd5, 1'b0);
    wait_idle();

    // back-to-back: second request queued 100 cycles in
    done_cycs.delete();
    tick(1'b1, 10'd1023, 1'b1);
    idle(99);
    tick(1'b1, 10'd7, 1'b0);
    wait_idle();
    chk("done_count", done_cycs.size(), 2);
    if (done_cycs.size() == 2) chk("done_gap", done_cycs[1] - done_cycs[0], DEPTH);

    // three STARTs while busy: only the in-progress frame and idx 4 survive
    started.delete();
    tick(1'b1, 10'd10, 1'b0);
    idle(20);
    tick(1'b1, 10'd2, 1'b0);
    idle(10);
    tick(1'b1, 10'd3, 1'b1);
    idle(10);
    tick(1'b1, 10'd4, 1'b1);
    wait_idle();
    chk("latest_wins_frames", started.size(), 2);
    if (started.size() == 2) chk("latest_wins_idx", started[1], 4);

    // START exactly on the last address issue
    started.delete();
    s0 = cyc;
    tick(1'b1, 10'd33, 1'b1);
    idle(DEPTH - 1);
    tick(1'b1, 10'd44, 1'b0);
    wait_idle();
    chk("edge_frames", started.size(), 2);

    // randomized requests and gaps
    for (int r = 0; r < 6; r++) begin
      tick(1'b1, 10'($urandom), 1'($urandom));
      idle($urandom_range(0, 300));
    end
    wait_idle();

    // reset in the middle of a frame (around beat 100)
    tick(1'b1, 10'd9, 1'b1);
    idle(102);
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1 chk_reset_outputs("midrst");
    repeat (2) @(negedge CLK);
    #1 RST_N = 1'b1;
    tick(1'b1, 10'd0, 1'b0);
    wait_idle();

    // DEPTH=1 build: single beat with DONE, BUSY low one cycle later
    w1 = word(1'b0, 10'd3, 8'd0);
    @(negedge CLK);
    #1 s1_start = 1'b1;
    s1_idx = 10'd3;
    s1_seg = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge CLK);
      if (j == 0) s1_start = 1'b0;
      chk("d1_valid", s1_valid, j == 3);
      chk("d1_done", s1_done, j == 3);
      chk("d1_busy", s1_busy, j <= 3);
      if (j == 3) begin
        chk("d1_phase", s1_phase, w1[7:0]);
        chk("d1_int", s1_int, w1[15:8]);
        chk("d1_addr", s1_daddr, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1);
  end

endmodule

// File: doc/stm_gain_sequencer.md
# stm_gain_sequencer

Sequences reads of the gain-STM segment memory for one gain frame: on a start request it drives `GAIN_IDX`/`SEGMENT` and sweeps `GAIN_ADDR` over all `DEPTH` transducers. It absorbs the memory's fixed 2-cycle read latency and unpacks each 64-bit `VALUE` word into a per-transducer phase/intensity stream. It sits between the STM timing logic (requester) and `stm_bus.out_gain_port` (memory), with `GAIN_STM_MODE` asserted externally.

## Interface
- `DEPTH`, 249, number of transducers per frame; legal range 1..256.
- `CLK`  in  1  system clock (20.48 MHz).
- `RST_N`  in  1  reset; one clock; reset is asynchronous and active-low.
- `START`  in  1  one-cycle request to read frame `REQ_IDX` of segment `REQ_SEGMENT`.
- `REQ_IDX`  in  10  gain frame index, sampled with `START`.
- `REQ_SEGMENT`  in  1  segment select, sampled with `START`.
- `BUSY`  out  1  high from accepted start until the last beat of the last frame.
- `GAIN_IDX`  out  10  frame index to memory.
- `GAIN_ADDR`  out  8  transducer address to memory.
- `SEGMENT`  out  1  segment to memory.
- `VALUE`  in  64  memory read data; corresponds to the address presented 2 cycles earlier.
- `DOUT_VALID`  out  1  phase/intensity beat valid.
- `DOUT_ADDR`  out  8  transducer index of the current beat.
- `PHASE`  out  8  phase of transducer `DOUT_ADDR`.
- `INTENSITY`  out  8  intensity of transducer `DOUT_ADDR`.
- `DONE`  out  1  one-cycle pulse, coincident with the last beat of a frame.

## Operation
- FSM states: IDLE, RUN.
- IDLE + `START`: latch `REQ_IDX`/`REQ_SEGMENT` onto `GAIN_IDX`/`SEGMENT`, set `GAIN_ADDR`=0, go to RUN.
- RUN: `GAIN_ADDR` increments by 1 each cycle up to `DEPTH-1`.
- `START` while not IDLE: capture into a one-entry pending slot. A later `START` overwrites the slot (latest wins).
- When `GAIN_ADDR`=`DEPTH-1` is issued:
  - If pending is set, load the pending idx/segment, set `GAIN_ADDR`=0 on the next cycle, clear pending, and stay in RUN. There is no gap.
  - Otherwise return to IDLE. `GAIN_ADDR`, `GAIN_IDX` and `SEGMENT` hold their last values.
- `START` coinciding with the last address issue goes to the pending slot and is served gaplessly.
- Each issued address is carried down a 2-stage tag pipeline with valid, addr and last flags, so frames are in flight back-to-back.
- Unpack: lane = `addr[1:0]`.
  - `PHASE` = `VALUE[16*lane +: 8]`.
  - `INTENSITY` = `VALUE[16*lane+8 +: 8]`.
- `BUSY` = (state != IDLE) or any valid tag in flight.
- `DEPTH`=1: the frame is a single address; `DONE` accompanies the only beat.

## Timing
- Reset values: `BUSY`, `DOUT_VALID` and `DONE` = 0. `GAIN_IDX`, `GAIN_ADDR`, `SEGMENT`, `DOUT_ADDR`, `PHASE` and `INTENSITY` = 0. Pending slot cleared, FSM in IDLE.
- `START` sampled at edge t:
  - Address k is driven during cycle t+1+k.
  - Its `VALUE` is valid during cycle t+3+k.
  - The registered beat is output during cycle t+4+k.
- Frame beats occupy t+4 .. t+3+DEPTH. `DONE` is at t+3+DEPTH.
- A pending frame's first beat directly follows the previous frame's `DONE` beat.
- `BUSY` rises at t+1 and falls at t+4+DEPTH if no further frame is queued.
- Reset asserted mid-frame: all outputs return to reset values asynchronously. In-flight beats and the pending slot are discarded. No `DONE` is emitted.

## Structure
- The following belong in the shared STM package, alongside the existing memory-latency constant:
  - state enum `gain_seq_state_t`.
  - `GAIN_MEM_LATENCY`=2.
- Sub-module `stm_gain_unpack`:
  - Registered lane select.
  - `VALUE` + tag in; `PHASE`, `INTENSITY`, `DOUT_ADDR`, `DOUT_VALID`, `DONE` out.
- The sequencer FSM, address counter and pending slot live in the top module.

## Test plan
- Memory model preloaded with random data for segments 0/1, `START` idx=5, seg=0 -> 249 consecutive beats at t+4..t+252; every `PHASE`/`INTENSITY` matches the model for addr 0..248; `DONE` at t+252 only.
- `START` idx=1023 seg=1, then `START` idx=7 seg=0 at t+100 -> second frame's addr 0 issued at t+250; beats gapless; two `DONE` pulses 249 cycles apart.
- Three `START`s while busy (idx 2, 3, 4) -> only frames for the in-progress request and idx 4 are produced; idx 2 and 3 are dropped.
- `START` on the exact cycle `GAIN_ADDR`=248 is issued -> next frame is served with zero-cycle gap; `BUSY` never drops.
- `RST_N` low at beat 100 -> all outputs 0 immediately, no `DONE`; after release, `START` idx=0 produces a clean full frame.
- `DEPTH`=1 build, `START` idx=3 -> single beat at t+4 with `DONE`=1; `BUSY` low at t+5.
